ghost_chase: RTL and testbench
==============================

GHOST_CHASE -- requirements
Module: ghost_chase

Interface
REQ-001 Parameter X_MIN, default 0, lowest legal ghost x.
REQ-002 Parameter X_MAX, default 639, highest legal ghost x.
REQ-003 Parameter Y_MIN, default 0, lowest legal ghost y.
REQ-004 Parameter Y_MAX, default 479, highest legal ghost y.
REQ-005 Parameter HOME_X, default 320, and HOME_Y, default 240, SHALL give the ghost's home position.
REQ-006 Parameter SCAT_X, default 16, and SCAT_Y, default 16, SHALL give the scatter-corner target.
REQ-007 Parameter STEP, default 2, maximum pixels moved per tick.
REQ-008 Parameter CATCH_R, default 8, catch radius in pixels on each axis.
REQ-009 Parameter SCATTER_TICKS, default 4, number of ticks spent in SCATTER.
REQ-010 Port clk, input, 1, single clock; all state changes on the rising edge only.
REQ-011 Port clrn, input, 1, synchronous active-low reset.
REQ-012 Port enable, input, 1, game-running level; low returns the ghost home.
REQ-013 Port tick, input, 1, one-cycle move-strobe pulse.
REQ-014 Port pac_x, input, 10, Pac-Man x pixel.
REQ-015 Port pac_y, input, 10, Pac-Man y pixel.
REQ-016 Port ghost_x, output, 10, registered ghost x; feeds the display GhostX input.
REQ-017 Port ghost_y, output, 9, registered ghost y; feeds the display GhostY input.
REQ-018 Port dir, output, 2, last move direction: 00 right, 01 left, 10 down, 11 up.
REQ-019 Port state, output, 2, FSM state: 00 HOME, 01 SCATTER, 10 CHASE, 11 CAUGHT.
REQ-020 Port caught, output, 1, high exactly while state = CAUGHT.

Function
REQ-021 All outputs SHALL be registered, with no combinational path from input to output.
REQ-022 HOME: ghost SHALL be held at (HOME_X, HOME_Y); enable=1 -> SCATTER at the next edge; a tick in that same cycle SHALL be ignored.
REQ-023 SCATTER: the target SHALL be (SCAT_X, SCAT_Y); the tick counter SHALL increment on each tick; the edge of the SCATTER_TICKS-th tick SHALL perform that tick's move and enter CHASE.
REQ-024 CHASE: the target SHALL be (pac_x, pac_y), each clamped to [X_MIN..X_MAX] / [Y_MIN..Y_MAX].
REQ-025 Move on a tick edge in SCATTER or CHASE: dx = target_x - ghost_x and dy = target_y - ghost_y SHALL be computed signed, 11 bits wide.
REQ-026 Axis selection: |dx| >= |dy| SHALL move on x (ties go to x); otherwise the move SHALL be on y.
REQ-027 Step size SHALL be min(STEP, |d|) in the sign of d; the result SHALL be clamped to bounds.
REQ-028 dir SHALL update only when a nonzero move occurs.
REQ-029 dx = dy = 0: no move; dir SHALL hold.
REQ-030 Catch condition: |pac_x - ghost_x| <= CATCH_R and |pac_y - ghost_y| <= CATCH_R, evaluated on registered ghost position and current pac inputs.
REQ-031 Catch condition true in SCATTER or CHASE -> CAUGHT at the next edge; catch SHALL take priority over a same-cycle tick, so no move occurs.
REQ-032 CAUGHT: ticks SHALL be ignored and the position held until enable=0.
REQ-033 enable=0 in any state SHALL go to HOME at the next edge: position reloaded to home, scatter counter cleared, dir=00, caught=0.
REQ-034 Ticks SHALL never be queued; a tick arriving while not in SCATTER or CHASE SHALL be dropped.

Reset
REQ-035 clrn=0 at an edge SHALL produce: state HOME, ghost_x=HOME_X, ghost_y=HOME_Y, dir=00, caught=0, scatter counter 0.
REQ-036 Reset SHALL override enable and tick in the same cycle.
REQ-037 Reset asserted mid-move or mid-scatter SHALL discard all progress.

Verification
REQ-038 clrn=0 for 2 cycles with tick=1 -> ghost (320,240), state 00, dir 00, caught 0.
REQ-039 enable=1, then 4 ticks -> x 318, 316, 314, 312 with y=240 and dir 01; state 10 after the 4th tick.
REQ-040 CHASE, ghost (312,240), pac (312,300), one tick -> ghost (312,242), dir 10.
REQ-041 Ghost (312,242), pac (318,248) -> state 11 and caught 1 at the next edge; a same-cycle tick leaves position unchanged; enable=0 -> state 00 at (320,240) with caught 0.
REQ-042 CHASE, ghost x=637 y=240, pac (700,240), 2 ticks -> x 639, then 639; dir 00 throughout.
REQ-043 CHASE, ghost (312,240), pac (313,400) -> |dy| > |dx|, so y moves: 242, dir 10; separately, pac (313,240) -> x 313 via a 1-pixel step.

Source files
------------

// File: rtl/ghost_chase.sv
// Ghost sprite controller: home / scatter / chase / caught FSM that steps the ghost
// toward a target on each move tick and flags a catch when Pac-Man is within reach.
module ghost_chase #(
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 639,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = 479,
  parameter int HOME_X        = 320,
  parameter int HOME_Y        = 240,
  parameter int SCAT_X        = 16,
  parameter int SCAT_Y        = 16,
  parameter int STEP          = 2,
  parameter int CATCH_R       = 8,
  parameter int SCATTER_TICKS = 4
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       enable,
  input  logic       tick,
  input  logic [9:0] pac_x,
  input  logic [9:0] pac_y,
  output logic [9:0] ghost_x,
  output logic [8:0] ghost_y,
  output logic [1:0] dir,
  output logic [1:0] state,
  output logic       caught
);

  localparam logic [1:0] S_HOME   = 2'b00;
  localparam logic [1:0] S_SCAT   = 2'b01;
  localparam logic [1:0] S_CHASE  = 2'b10;
  localparam logic [1:0] S_CAUGHT = 2'b11;

  localparam logic [1:0] D_RIGHT = 2'b00;
  localparam logic [1:0] D_LEFT  = 2'b01;
  localparam logic [1:0] D_DOWN  = 2'b10;
  localparam logic [1:0] D_UP    = 2'b11;

  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] CATCH_S = 11'(CATCH_R);
  localparam logic [7:0]         CNT_END = 8'(SCATTER_TICKS - 1);

  function automatic logic signed [10:0] abs11(input logic signed [10:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic signed [10:0] clamp11(input logic signed [10:0] v,
                                                 input int lo, input int hi);
    if (v < lo) return 11'(lo);
    if (v > hi) return 11'(hi);
    return v;
  endfunction

  // Move at most STEP pixels along d, never overshooting the target.
  function automatic logic signed [10:0] step_toward(input logic signed [10:0] pos,
                                                     input logic signed [10:0] d);
    logic signed [10:0] mag;
    mag = (abs11(d) < STEP_S) ? abs11(d) : STEP_S;
    return (d < 0) ? pos - mag : pos + mag;
  endfunction

  logic [7:0]         cnt, cnt_nxt;
  logic [1:0]         state_nxt, dir_nxt;
  logic [9:0]         gx_nxt;
  logic [8:0]         gy_nxt;
  logic signed [10:0] gx, gy, tx, ty, dx, dy, pdx, pdy, nx, ny;
  logic               hit, moving;

  assign gx  = signed'({1'b0, ghost_x});
  assign gy  = signed'({2'b00, ghost_y});
  assign tx  = (state == S_CHASE) ? clamp11(signed'({1'b0, pac_x}), X_MIN, X_MAX) : 11'(SCAT_X);
  assign ty  = (state == S_CHASE) ? clamp11(signed'({1'b0, pac_y}), Y_MIN, Y_MAX) : 11'(SCAT_Y);
  assign dx  = tx - gx;
  assign dy  = ty - gy;
  assign pdx = signed'({1'b0, pac_x}) - gx;
  assign pdy = signed'({1'b0, pac_y}) - gy;
  assign hit = (abs11(pdx) <= CATCH_S) && (abs11(pdy) <= CATCH_S);

  // Stage p0: state and position registers
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state   <= S_HOME;
      ghost_x <= 10'(HOME_X);
      ghost_y <= 9'(HOME_Y);
      dir     <= D_RIGHT;
      cnt     <= '0;
      caught  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ghost_x <= gx_nxt;
      ghost_y <= gy_nxt;
      dir     <= dir_nxt;
      cnt     <= cnt_nxt;
      caught  <= (state_nxt == S_CAUGHT);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HOME:   if (enable) state_nxt = S_SCAT;
      S_SCAT:   if (hit) state_nxt = S_CAUGHT;
                else if (tick && cnt == CNT_END) state_nxt = S_CHASE;
      S_CHASE:  if (hit) state_nxt = S_CAUGHT;
      default:  state_nxt = S_CAUGHT;
    endcase
    if (!enable) state_nxt = S_HOME;
  end

  always_comb begin
    gx_nxt  = ghost_x;
    gy_nxt  = ghost_y;
    dir_nxt = dir;
    cnt_nxt = cnt;
    nx      = gx;
    ny      = gy;
    // A catch outranks a same-cycle tick, so the ghost freezes where it was.
    moving  = enable && tick && !hit && (state == S_SCAT || state == S_CHASE);
    if (moving) begin
      if (state == S_SCAT) cnt_nxt = cnt + 8'd1;
      if (abs11(dx) >= abs11(dy)) begin
        nx = clamp11(step_toward(gx, dx), X_MIN, X_MAX);
        if (nx != gx) begin
          gx_nxt  = 10'(nx);
          dir_nxt = (dx < 0) ? D_LEFT : D_RIGHT;
        end
      end else begin
        ny = clamp11(step_toward(gy, dy), Y_MIN, Y_MAX);
        if (ny != gy) begin
          gy_nxt  = 9'(ny);
          dir_nxt = (dy < 0) ? D_UP : D_DOWN;
        end
      end
    end
    if (!enable || state == S_HOME) begin
      gx_nxt  = 10'(HOME_X);
      gy_nxt  = 9'(HOME_Y);
      dir_nxt = D_RIGHT;
      cnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_ghost_chase.sv
// Directed bench for ghost_chase: a default instance plus one with zero catch radius
// so the ghost can be walked right up to Pac-Man.
module tb_ghost_chase;

  logic       clk = 1'b0;
  logic       clrn, enable, tick;
  logic [9:0] pac_x, pac_y;
  logic [9:0] gx1, gx2;
  logic [8:0] gy1, gy2;
  logic [1:0] dir1, dir2, st1, st2;
  logic       ct1, ct2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ghost_chase dut1 (
    .clk(clk), .clrn(clrn), .enable(enable), .tick(tick),
    .pac_x(pac_x), .pac_y(pac_y),
    .ghost_x(gx1), .ghost_y(gy1), .dir(dir1), .state(st1), .caught(ct1)
  );

  ghost_chase #(.CATCH_R(0)) dut2 (
    .clk(clk), .clrn(clrn), .enable(enable), .tick(tick),
    .pac_x(pac_x), .pac_y(pac_y),
    .ghost_x(gx2), .ghost_y(gy2), .dir(dir2), .state(st2), .caught(ct2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    clrn = 1'b0; enable = 1'b1; tick = 1'b1;
    pac_x = 10'd312; pac_y = 10'd300;
    step(); step();
    chk("rst_x", gx1, 320);  chk("rst_y", gy1, 240);
    chk("rst_state", st1, 0); chk("rst_dir", dir1, 0);
    chk("rst_caught", ct1, 0); chk("rst_x2", gx2, 320);

    clrn = 1'b1;
    step();
    chk("home_tick_ign_state", st1, 1);
    chk("home_tick_ign_x", gx1, 320);
    tick = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_tick();
      chk("scat_x", gx1, 318 - 2 * i);
      chk("scat_y", gy1, 240);
      chk("scat_dir", dir1, 1);
      chk("scat_state", st1, (i == 3) ? 2 : 1);
    end

    do_tick();
    chk("chase_y_x", gx1, 312); chk("chase_y_y", gy1, 242);
    chk("chase_y_dir", dir1, 2);

    pac_x = 10'd318; pac_y = 10'd248;
    do_tick();
    chk("catch_state", st1, 3); chk("catch_flag", ct1, 1);
    chk("catch_x", gx1, 312);   chk("catch_y", gy1, 242);
    do_tick();
    chk("caught_hold_x", gx1, 312); chk("caught_hold_y", gy1, 242);
    chk("caught_hold_state", st1, 3);

    enable = 1'b0;
    step();
    chk("release_state", st1, 0); chk("release_x", gx1, 320);
    chk("release_y", gy1, 240);   chk("release_caught", ct1, 0);
    chk("release_dir", dir1, 0);

    pac_x = 10'd313; pac_y = 10'd400;
    enable = 1'b1;
    step();
    for (int i = 0; i < 4; i++) do_tick();
    chk("pre43_state", st2, 2); chk("pre43_x", gx2, 312);
    do_tick();
    chk("dy_major_y", gy1, 242); chk("dy_major_x", gx1, 312);
    chk("dy_major_dir", dir1, 2); chk("dy_major_y2", gy2, 242);

    enable = 1'b0; step();
    enable = 1'b1; step();
    for (int i = 0; i < 4; i++) do_tick();
    pac_x = 10'd313; pac_y = 10'd240;
    do_tick();
    chk("one_px_x", gx2, 313); chk("one_px_y", gy2, 240);
    chk("one_px_dir", dir2, 0);
    chk("catch_prio_state", st1, 3); chk("catch_prio_x", gx1, 312);

    pac_x = 10'd1023; pac_y = 10'd240;
    for (int i = 0; i < 162; i++) do_tick();
    chk("run_x", gx2, 637); chk("run_state", st2, 2);

    pac_x = 10'd700;
    do_tick();
    chk("edge_x_a", gx2, 639); chk("edge_dir_a", dir2, 0);
    do_tick();
    chk("edge_x_b", gx2, 639); chk("edge_dir_b", dir2, 0);
    chk("edge_y", gy2, 240);

    enable = 1'b0; step();
    enable = 1'b1; step();
    do_tick(); do_tick();
    chk("mid_scat_x", gx1, 316);
    clrn = 1'b0; tick = 1'b1;
    step();
    chk("midrst_state", st1, 0); chk("midrst_x", gx1, 320);
    chk("midrst_dir", dir1, 0);
    clrn = 1'b1; tick = 1'b0;
    step();
    for (int i = 0; i < 3; i++) do_tick();
    chk("cnt_cleared_state", st1, 1); chk("cnt_cleared_x", gx1, 314);
    do_tick();
    chk("cnt_end_state", st1, 2); chk("cnt_end_x", gx1, 312);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
